// File: rtl/draw_pkg.sv
// Shared constants, command and state encodings for the race game pixel engine.
package draw_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned CAR_W    = 8;
    localparam int unsigned CAR_H    = 8;

    localparam logic [2:0] BG_COLOUR     = 3'b000;
    localparam logic [2:0] CAR_COLOUR    = 3'b100;
    localparam logic [2:0] WINDOW_COLOUR = 3'b111;
    localparam logic [2:0] WIN_COLOUR    = 3'b010;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_BG,
        CMD_CAR,
        CMD_ERASE,
        CMD_WIN
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/raster_counter.sv
// Column/row scan counters for a width x height region, x fastest.
module raster_counter (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       clear,
    input  logic       step,
    input  logic [7:0] width,
    input  logic [6:0] height,
    output logic [7:0] col,
    output logic [6:0] row,
    output logic       last
);

    logic [7:0] r_col;
    logic [6:0] r_row;
    logic       w_colEnd;
    logic       w_rowEnd;

    assign w_colEnd = (r_col == width - 8'd1);
    assign w_rowEnd = (r_row == height - 7'd1);

    always_ff @(posedge Clock) begin
        if (Reset || clear) begin
            r_col <= 8'd0;
            r_row <= 7'd0;
        end else if (step) begin
            if (w_colEnd) begin
                r_col <= 8'd0;
                r_row <= r_row + 7'd1;
            end else begin
                r_col <= r_col + 8'd1;
            end
        end
    end

    assign col  = r_col;
    assign row  = r_row;
    assign last = w_colEnd && w_rowEnd;

endmodule

// File: rtl/race_draw_engine.sv
// Draw-command engine: latches one command, raster-scans its region one pixel
// per cycle toward the VGA adapter, then pulses the matching done flag.
module race_draw_engine #(
    parameter int unsigned SCREEN_W      = draw_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H      = draw_pkg::SCREEN_H,
    parameter int unsigned CAR_W         = draw_pkg::CAR_W,
    parameter int unsigned CAR_H         = draw_pkg::CAR_H,
    parameter logic [2:0]  BG_COLOUR     = draw_pkg::BG_COLOUR,
    parameter logic [2:0]  CAR_COLOUR    = draw_pkg::CAR_COLOUR,
    parameter logic [2:0]  WINDOW_COLOUR = draw_pkg::WINDOW_COLOUR,
    parameter logic [2:0]  WIN_COLOUR    = draw_pkg::WIN_COLOUR
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       draw_background,
    input  logic       draw_car,
    input  logic       erase_car,
    input  logic       draw_win_screen,
    input  logic [7:0] car_x,
    input  logic [6:0] car_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       done_background,
    output logic       done_car,
    output logic       done_erase,
    output logic       done_win,
    output logic       busy
);
    import draw_pkg::*;

    state_t     r_state, w_nextState;
    cmd_t       r_cmd, w_reqCmd, w_cmd;
    logic [7:0] r_orgX, w_orgX, r_width, w_width;
    logic [6:0] r_orgY, w_orgY, r_height, w_height;
    logic [7:0] w_col;
    logic [6:0] w_row;
    logic       w_last, w_step, w_clear, w_emit, w_finish, w_accept;
    logic [8:0] w_sumX;
    logic [7:0] w_sumY;
    logic       w_inside;
    logic [2:0] w_colour;
    logic       r_lastOut;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [2:0] r_colour;
    logic       r_plot, r_busy, r_doneBg, r_doneCar, r_doneErase, r_doneWin;

    raster_counter u_counter (
        .Clock  (Clock),
        .Reset  (Reset),
        .clear  (w_clear),
        .step   (w_step),
        .width  (w_width),
        .height (w_height),
        .col    (w_col),
        .row    (w_row),
        .last   (w_last)
    );

    always_comb begin
        w_reqCmd = CMD_NONE;
        if (draw_win_screen)      w_reqCmd = CMD_WIN;
        else if (draw_background) w_reqCmd = CMD_BG;
        else if (erase_car)       w_reqCmd = CMD_ERASE;
        else if (draw_car)        w_reqCmd = CMD_CAR;
    end

    // In IDLE the first pixel is built from the incoming request, since the
    // counters sit at zero and the latch has not been loaded yet.
    always_comb begin
        w_cmd    = r_cmd;
        w_orgX   = r_orgX;
        w_orgY   = r_orgY;
        w_width  = r_width;
        w_height = r_height;
        if (r_state == IDLE) begin
            w_cmd = w_reqCmd;
            if (w_reqCmd == CMD_WIN || w_reqCmd == CMD_BG) begin
                w_orgX   = 8'd0;
                w_orgY   = 7'd0;
                w_width  = 8'(SCREEN_W);
                w_height = 7'(SCREEN_H);
            end else begin
                w_orgX   = car_x;
                w_orgY   = car_y;
                w_width  = 8'(CAR_W);
                w_height = 7'(CAR_H);
            end
        end
    end

    assign w_sumX   = {1'b0, w_orgX} + {1'b0, w_col};
    assign w_sumY   = {1'b0, w_orgY} + {1'b0, w_row};
    assign w_inside = (w_sumX < 9'(SCREEN_W)) && (w_sumY < 8'(SCREEN_H));

    always_comb begin
        w_colour = BG_COLOUR;
        case (w_cmd)
            CMD_WIN: w_colour = WIN_COLOUR;
            CMD_CAR: w_colour = (w_row == 7'd1 && w_col >= 8'd2 && w_col <= 8'd5)
                                ? WINDOW_COLOUR : CAR_COLOUR;
            default: w_colour = BG_COLOUR;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        w_step      = 1'b0;
        w_clear     = 1'b0;
        w_emit      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_reqCmd != CMD_NONE) begin
                    w_nextState = RUN;
                    w_step      = 1'b1;
                    w_emit      = 1'b1;
                end
            end
            RUN: begin
                if (r_lastOut) begin
                    w_nextState = DONE;
                    w_finish    = 1'b1;
                end else begin
                    w_step = 1'b1;
                    w_emit = 1'b1;
                end
            end
            DONE: begin
                w_nextState = IDLE;
                w_clear     = 1'b1;
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign w_accept = w_emit && (r_state == IDLE);

    // Counters run one pixel ahead of the registered outputs; r_lastOut marks
    // that the pixel currently on the outputs is the final one.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_cmd       <= CMD_NONE;
            r_orgX      <= 8'd0;
            r_orgY      <= 7'd0;
            r_width     <= 8'd0;
            r_height    <= 7'd0;
            r_lastOut   <= 1'b0;
            r_x         <= 8'd0;
            r_y         <= 7'd0;
            r_colour    <= 3'd0;
            r_plot      <= 1'b0;
            r_busy      <= 1'b0;
            r_doneBg    <= 1'b0;
            r_doneCar   <= 1'b0;
            r_doneErase <= 1'b0;
            r_doneWin   <= 1'b0;
        end else begin
            r_plot      <= 1'b0;
            r_busy      <= 1'b0;
            r_doneBg    <= 1'b0;
            r_doneCar   <= 1'b0;
            r_doneErase <= 1'b0;
            r_doneWin   <= 1'b0;
            if (w_accept) begin
                r_cmd    <= w_reqCmd;
                r_orgX   <= w_orgX;
                r_orgY   <= w_orgY;
                r_width  <= w_width;
                r_height <= w_height;
            end
            if (w_emit) begin
                r_x       <= w_sumX[7:0];
                r_y       <= w_sumY[6:0];
                r_colour  <= w_colour;
                r_plot    <= w_inside;
                r_busy    <= 1'b1;
                r_lastOut <= w_last;
            end
            if (w_finish) begin
                r_lastOut   <= 1'b0;
                r_doneBg    <= (r_cmd == CMD_BG);
                r_doneCar   <= (r_cmd == CMD_CAR);
                r_doneErase <= (r_cmd == CMD_ERASE);
                r_doneWin   <= (r_cmd == CMD_WIN);
            end
        end
    end

    assign x               = r_x;
    assign y               = r_y;
    assign colour          = r_colour;
    assign plot            = r_plot;
    assign busy            = r_busy;
    assign done_background = r_doneBg;
    assign done_car        = r_doneCar;
    assign done_erase      = r_doneErase;
    assign done_win        = r_doneWin;

endmodule

// File: tb/tb_race_draw_engine.sv
// Directed bench for race_draw_engine: reset, car/erase/full-screen draws,
// clipping, command priority, mid-draw input changes and mid-run reset.
module tb_race_draw_engine;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       draw_background = 1'b0;
    logic       draw_car = 1'b0;
    logic       erase_car = 1'b0;
    logic       draw_win_screen = 1'b0;
    logic [7:0] car_x = 8'd0;
    logic [6:0] car_y = 7'd0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       done_background, done_car, done_erase, done_win, busy;

    int tests = 0;
    int failures = 0;

    race_draw_engine dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .draw_background (draw_background),
        .draw_car        (draw_car),
        .erase_car       (erase_car),
        .draw_win_screen (draw_win_screen),
        .car_x           (car_x),
        .car_y           (car_y),
        .x               (x),
        .y               (y),
        .colour          (colour),
        .plot            (plot),
        .done_background (done_background),
        .done_car        (done_car),
        .done_erase      (done_erase),
        .done_win        (done_win),
        .busy            (busy)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        tests++;
        if (plot !== 1'b0) begin failures++; $display("[TB] FAIL reset_plot: got %b expected 0", plot); end
        tests++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tests++;
        if (x !== 8'd0 || y !== 7'd0) begin failures++; $display("[TB] FAIL reset_xy: got (%0d,%0d) expected (0,0)", x, y); end
        tests++;
        if (colour !== 3'd0) begin failures++; $display("[TB] FAIL reset_colour: got %b expected 000", colour); end
        tests++;
        if ({done_background, done_car, done_erase, done_win} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_done: got %b expected 0000", {done_background, done_car, done_erase, done_win});
        end
        Reset = 1'b0;
        tick();
        tests++;
        if ({plot, busy} !== 2'b00) begin failures++; $display("[TB] FAIL idle_quiet: got plot/busy %b expected 00", {plot, busy}); end
    endtask

    task automatic test_car_draw();
        int bad = 0;
        int plots = 0;
        int badK = 0;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        logic [20:0] gotV, expV, firstGot, firstExp;
        firstGot = '0;
        firstExp = '0;
        car_x = 8'd10;
        car_y = 7'd20;
        draw_car = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k == 1) draw_car = 1'b0;
            ex = 8'(10 + (k - 1) % 8);
            ey = 7'(20 + (k - 1) / 8);
            ec = (ey == 7'd21 && ex >= 8'd12 && ex <= 8'd15) ? 3'b111 : 3'b100;
            if (plot === 1'b1) plots++;
            gotV = {plot, busy, x, y, colour, done_car};
            expV = {1'b1, 1'b1, ex, ey, ec, 1'b0};
            if (gotV !== expV) begin
                if (bad == 0) begin badK = k; firstGot = gotV; firstExp = expV; end
                bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL car_pixels: %0d bad cycles, first cycle %0d got %h expected %h", bad, badK, firstGot, firstExp);
        end
        tests++;
        if (plots != 64) begin failures++; $display("[TB] FAIL car_plot_count: got %0d expected 64", plots); end
        tick();
        tests++;
        if ({done_car, plot, busy} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL car_done: cycle 65 done/plot/busy got %b expected 100", {done_car, plot, busy});
        end
        tick();
        tests++;
        if (done_car !== 1'b0) begin failures++; $display("[TB] FAIL car_done_width: got %b expected 0", done_car); end
    endtask

    task automatic test_car_x_change();
        int bad = 0;
        int badK = 0;
        logic [7:0] badX = 8'd0;
        logic [7:0] ex;
        car_x = 8'd10;
        car_y = 7'd20;
        draw_car = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k == 1) draw_car = 1'b0;
            if (k == 3) car_x = 8'd50;
            ex = 8'(10 + (k - 1) % 8);
            if (x !== ex || plot !== 1'b1) begin
                if (bad == 0) begin badK = k; badX = x; end
                bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL car_x_change: %0d bad cycles, first cycle %0d x got %0d expected %0d", bad, badK, badX, 8'(10 + (badK - 1) % 8));
        end
        tick();
        tests++;
        if (done_car !== 1'b1) begin failures++; $display("[TB] FAIL car_x_change_done: got %b expected 1", done_car); end
        tick();
        car_x = 8'd0;
    endtask

    task automatic test_erase_clip();
        int bad = 0;
        int plots = 0;
        int badK = 0;
        int col, row;
        logic ep;
        car_x = 8'd156;
        car_y = 7'd118;
        erase_car = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k == 1) erase_car = 1'b0;
            col = (k - 1) % 8;
            row = (k - 1) / 8;
            ep = (156 + col < 160) && (118 + row < 120);
            if (plot === 1'b1) plots++;
            if (plot !== ep || busy !== 1'b1 || done_erase !== 1'b0 ||
                (ep && (x !== 8'(156 + col) || y !== 7'(118 + row) || colour !== 3'b000))) begin
                if (bad == 0) badK = k;
                bad++;
            end
        end
        tests++;
        if (bad != 0) begin failures++; $display("[TB] FAIL erase_pixels: %0d bad cycles, first cycle %0d", bad, badK); end
        tests++;
        if (plots != 8) begin failures++; $display("[TB] FAIL erase_plot_count: got %0d expected 8", plots); end
        tick();
        tests++;
        if ({done_erase, plot, busy} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL erase_done: cycle 65 done/plot/busy got %b expected 100", {done_erase, plot, busy});
        end
        tick();
        tests++;
        if (done_erase !== 1'b0) begin failures++; $display("[TB] FAIL erase_done_width: got %b expected 0", done_erase); end
    endtask

    task automatic test_background();
        int bad = 0;
        int plots = 0;
        int badK = 0;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [20:0] gotV, expV, firstGot, firstExp;
        firstGot = '0;
        firstExp = '0;
        draw_background = 1'b1;
        for (int k = 1; k <= 19200; k++) begin
            tick();
            ex = 8'((k - 1) % 160);
            ey = 7'((k - 1) / 160);
            if (plot === 1'b1) plots++;
            gotV = {plot, busy, x, y, colour, done_background};
            expV = {1'b1, 1'b1, ex, ey, 3'b000, 1'b0};
            if (gotV !== expV) begin
                if (bad == 0) begin badK = k; firstGot = gotV; firstExp = expV; end
                bad++;
            end
        end
        tests++;
        if (bad != 0) begin
            failures++;
            $display("[TB] FAIL bg_pixels: %0d bad cycles, first cycle %0d got %h expected %h", bad, badK, firstGot, firstExp);
        end
        tests++;
        if (plots != 19200) begin failures++; $display("[TB] FAIL bg_plot_count: got %0d expected 19200", plots); end
        tick();
        tests++;
        if ({done_background, plot, busy} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL bg_done: cycle 19201 done/plot/busy got %b expected 100", {done_background, plot, busy});
        end
        draw_background = 1'b0;
        tick();
        tests++;
        if ({done_background, plot} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL bg_done_once: got done/plot %b expected 00", {done_background, plot});
        end
    endtask

    task automatic test_win_priority();
        int bad = 0;
        int badK = 0;
        int carBad = 0;
        logic [7:0] ex;
        logic [6:0] ey;
        car_x = 8'd30;
        car_y = 7'd40;
        draw_car = 1'b1;
        draw_win_screen = 1'b1;
        for (int k = 1; k <= 19200; k++) begin
            tick();
            if (k == 1) draw_win_screen = 1'b0;
            ex = 8'((k - 1) % 160);
            ey = 7'((k - 1) / 160);
            if ({plot, x, y, colour, done_car, done_win} !== {1'b1, ex, ey, 3'b010, 1'b0, 1'b0}) begin
                if (bad == 0) badK = k;
                bad++;
            end
        end
        tests++;
        if (bad != 0) begin failures++; $display("[TB] FAIL win_pixels: %0d bad cycles, first cycle %0d", bad, badK); end
        tick();
        tests++;
        if ({done_win, done_car, plot} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL win_done: cycle 19201 win/car/plot got %b expected 100", {done_win, done_car, plot});
        end
        tick();
        tests++;
        if ({done_win, plot, busy} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL win_idle: cycle 19202 done/plot/busy got %b expected 000", {done_win, plot, busy});
        end
        tick();
        draw_car = 1'b0;
        tests++;
        if ({plot, busy, x, y, colour} !== {1'b1, 1'b1, 8'd30, 7'd40, 3'b100}) begin
            failures++;
            $display("[TB] FAIL held_car_start: got plot=%b busy=%b (%0d,%0d) c=%b expected plot=1 busy=1 (30,40) c=100",
                     plot, busy, x, y, colour);
        end
        for (int k = 2; k <= 64; k++) begin
            tick();
            if (plot !== 1'b1 || done_car !== 1'b0) carBad++;
        end
        tick();
        tests++;
        if (carBad != 0 || done_car !== 1'b1) begin
            failures++;
            $display("[TB] FAIL held_car_done: bad cycles %0d done_car got %b expected 1", carBad, done_car);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int noisy = 0;
        draw_background = 1'b1;
        for (int k = 1; k <= 500; k++) begin
            tick();
            if (k == 1) draw_background = 1'b0;
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tests++;
        if ({plot, busy} !== 2'b00) begin failures++; $display("[TB] FAIL midreset_plot_busy: got %b expected 00", {plot, busy}); end
        tests++;
        if (x !== 8'd0 || y !== 7'd0) begin failures++; $display("[TB] FAIL midreset_xy: got (%0d,%0d) expected (0,0)", x, y); end
        for (int k = 0; k < 3; k++) begin
            if ({done_background, done_car, done_erase, done_win, plot} !== 5'b00000) noisy++;
            tick();
        end
        tests++;
        if (noisy != 0) begin failures++; $display("[TB] FAIL midreset_quiet: got %0d noisy cycles expected 0", noisy); end
        car_x = 8'd70;
        car_y = 7'd60;
        draw_car = 1'b1;
        tick();
        draw_car = 1'b0;
        tests++;
        if ({plot, busy, x, y, colour} !== {1'b1, 1'b1, 8'd70, 7'd60, 3'b100}) begin
            failures++;
            $display("[TB] FAIL midreset_car_start: got plot=%b busy=%b (%0d,%0d) c=%b expected plot=1 busy=1 (70,60) c=100",
                     plot, busy, x, y, colour);
        end
        for (int k = 2; k <= 64; k++) tick();
        tick();
        tests++;
        if ({done_car, plot} !== 2'b10) begin failures++; $display("[TB] FAIL midreset_car_done: got done/plot %b expected 10", {done_car, plot}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_car_draw();
        test_car_x_change();
        test_erase_clip();
        test_background();
        test_win_priority();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
